// File: rtl/picorv32_pkg.sv
// Shared types for the PicoRV32 Wishbone fabric: bus beat structs, bridge FSM states, defaults.
package picorv32_pkg;

    typedef struct packed {
        logic [31:0] a_adr;
        logic [31:0] a_dat;
        logic [3:0]  a_sel;
        logic        a_we;
        logic        a_cyc;
        logic        a_stb;
    } wb_h2d_t;

    typedef struct packed {
        logic [31:0] d_dat;
        logic        d_ack;
        logic        d_err;
    } wb_d2h_t;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_BUS,
        BR_RESP
    } wb_br_state_e;

    localparam int unsigned WB_TIMEOUT_DEFAULT   = 64;
    localparam logic [31:0] WB_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // A zero strobe marks a read, which fetches the whole word.
    function automatic logic [3:0] wb_sel_for(input logic [3:0] wstrb);
        return (wstrb == 4'h0) ? 4'hF : wstrb;
    endfunction

endpackage

// File: rtl/picorv32_wb_bridge_if.sv
// Wishbone master-side link between the PicoRV32 bridge and the crossbar input.
interface picorv32_wb_bridge_if;
    import picorv32_pkg::*;

    wb_h2d_t wb_o;
    wb_d2h_t wb_i;

    modport master (output wb_o, input wb_i);
    modport slave  (input wb_o, output wb_i);

endinterface

// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to single-beat classic Wishbone master, with a bounded
// wait per access so unmapped or silent targets complete with an error instead of stalling.
module picorv32_wb_bridge
    import picorv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA      = WB_ERR_RDATA_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        mem_valid_i,
    input  logic [31:0]                 mem_addr_i,
    input  logic [31:0]                 mem_wdata_i,
    input  logic [3:0]                  mem_wstrb_i,
    output logic                        mem_ready_o,
    output logic [31:0]                 mem_rdata_o,
    picorv32_wb_bridge_if.master        wb,
    output logic                        bus_err_o,
    output logic [31:0]                 err_addr_o,
    input  logic                        err_clr_i
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    wb_br_state_e     r_state;
    wb_h2d_t          r_wb;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic             r_bus_err;
    logic [31:0]      r_err_addr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_addr;
    logic             r_is_write;

    logic             w_ack;
    logic             w_fail;

    // An ack arriving on the last allowed cycle still counts as success; d_err always wins.
    assign w_ack  = wb.wb_i.d_ack;
    assign w_fail = wb.wb_i.d_err | (~wb.wb_i.d_ack & (r_count == CNT_LAST));

    assign wb.wb_o     = r_wb;
    assign mem_ready_o = r_ready;
    assign mem_rdata_o = r_rdata;
    assign bus_err_o   = r_bus_err;
    assign err_addr_o  = r_err_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= BR_IDLE;
            r_wb       <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_err_addr <= '0;
            r_count    <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (err_clr_i) begin
                r_bus_err  <= 1'b0;
                r_err_addr <= '0;
            end

            case (r_state)
                BR_IDLE: begin
                    if (mem_valid_i) begin
                        r_addr     <= mem_addr_i;
                        r_is_write <= |mem_wstrb_i;
                        r_wb.a_adr <= mem_addr_i & ~32'h3;
                        r_wb.a_dat <= mem_wdata_i;
                        r_wb.a_sel <= wb_sel_for(mem_wstrb_i);
                        r_wb.a_we  <= |mem_wstrb_i;
                        r_wb.a_cyc <= 1'b1;
                        r_wb.a_stb <= 1'b1;
                        r_count    <= '0;
                        r_state    <= BR_BUS;
                    end
                end

                BR_BUS: begin
                    if (r_count != CNT_MAX) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_fail || w_ack) begin
                        r_wb.a_cyc <= 1'b0;
                        r_wb.a_stb <= 1'b0;
                        r_wb.a_we  <= 1'b0;
                        r_ready    <= 1'b1;
                        r_state    <= BR_RESP;
                    end
                    // The error capture overrides a same-cycle clear from above.
                    if (w_fail) begin
                        r_rdata   <= ERR_RDATA;
                        r_bus_err <= 1'b1;
                        if (!r_bus_err || err_clr_i) begin
                            r_err_addr <= r_addr;
                        end
                    end else if (w_ack) begin
                        r_rdata <= r_is_write ? 32'h0 : wb.wb_i.d_dat;
                    end
                end

                BR_RESP: begin
                    r_state <= BR_IDLE;
                end

                default: begin
                    r_state <= BR_IDLE;
                end
            endcase
        end
    end

endmodule
